bram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 8192 x 64-bit single-port on-chip boot/firmware BRAM. It shares the one storage port between two valid/ready requesters, typically the core's memory bus and the debug/loader path. It drives the storage port's enable, address, write data and per-byte write enables, and captures the storage's registered read data into per-port response registers.

---
 rtl/bram_arbiter.sv | 128 ++++++++++++
 tb/tb_bram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-port valid/ready arbiter and sequencer for the single-port 8192 x 64 boot BRAM.
// Each port has one outstanding access; responses are captured from the storage's registered output.
module bram_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_W-1:0]     p0_req_addr,
  input  logic [DATA_W-1:0]     p0_req_wdata,
  input  logic [DATA_W/8-1:0]   p0_req_wstrb,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [DATA_W-1:0]     p0_resp_rdata,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_W-1:0]     p1_req_addr,
  input  logic [DATA_W-1:0]     p1_req_wdata,
  input  logic [DATA_W/8-1:0]   p1_req_wstrb,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [DATA_W-1:0]     p1_resp_rdata,

  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  output logic [DATA_W/8-1:0]   bram_we_perbyte,
  input  logic [DATA_W-1:0]     bram_rdata
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_INFLIGHT,
    SLOT_RESP
  } slot_e;

  slot_e             slot0_q, slot0_d;
  slot_e             slot1_q, slot1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              last_grant_q, last_grant_d;

  logic elig0, elig1;
  logic gnt0, gnt1;

  function automatic slot_e slot_next(input slot_e s, input logic gnt, input logic resp_ready);
    slot_e n;
    n = s;
    case (s)
      SLOT_IDLE:     n = gnt ? SLOT_INFLIGHT : SLOT_IDLE;
      SLOT_INFLIGHT: n = SLOT_RESP;
      SLOT_RESP:     n = resp_ready ? (gnt ? SLOT_INFLIGHT : SLOT_IDLE) : SLOT_RESP;
      default:       n = SLOT_IDLE;
    endcase
    return n;
  endfunction

  // A slot holding a response may be re-granted in the same cycle its response is accepted.
  always_comb begin
    elig0 = !reset && p0_req_valid &&
            ((slot0_q == SLOT_IDLE) || ((slot0_q == SLOT_RESP) && p0_resp_ready));
    elig1 = !reset && p1_req_valid &&
            ((slot1_q == SLOT_IDLE) || ((slot1_q == SLOT_RESP) && p1_resp_ready));

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (elig0 && elig1) begin
      if ((FIXED_PRIO != 0) || last_grant_q) gnt0 = 1'b1;
      else                                   gnt1 = 1'b1;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  always_comb begin
    slot0_d      = slot_next(slot0_q, gnt0, p0_resp_ready);
    slot1_d      = slot_next(slot1_q, gnt1, p1_resp_ready);
    rdata0_d     = (slot0_q == SLOT_INFLIGHT) ? bram_rdata : rdata0_q;
    rdata1_d     = (slot1_q == SLOT_INFLIGHT) ? bram_rdata : rdata1_q;
    last_grant_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_grant_q);
  end

  always_comb begin
    bram_en         = gnt0 | gnt1;
    bram_addr       = '0;
    bram_wdata      = '0;
    bram_we_perbyte = '0;
    if (gnt0) begin
      bram_addr       = p0_req_addr;
      bram_wdata      = p0_req_wdata;
      bram_we_perbyte = p0_req_wstrb;
    end else if (gnt1) begin
      bram_addr       = p1_req_addr;
      bram_wdata      = p1_req_wdata;
      bram_we_perbyte = p1_req_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot0_q      <= SLOT_IDLE;
      slot1_q      <= SLOT_IDLE;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign p0_req_ready  = gnt0;
  assign p1_req_ready  = gnt1;
  assign p0_resp_valid = (slot0_q == SLOT_RESP);
  assign p1_resp_valid = (slot1_q == SLOT_RESP);
  assign p0_resp_rdata = rdata0_q;
  assign p1_resp_rdata = rdata1_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a behavioural BRAM, scoreboard queues per port and a response monitor.
// A second instance with fixed priority shares the stimulus for the priority comparisons.
module tb_bram_arbiter;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  localparam logic [DW-1:0] D10 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D20 = 64'hA5A5_0000_1234_5678;
  localparam logic [DW-1:0] D21 = 64'h0F0F_F0F0_CAFE_BABE;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_req_valid, p1_req_valid;
  logic [AW-1:0] p0_req_addr, p1_req_addr;
  logic [DW-1:0] p0_req_wdata, p1_req_wdata;
  logic [SW-1:0] p0_req_wstrb, p1_req_wstrb;
  logic          p0_resp_ready, p1_resp_ready;

  logic          p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  logic [DW-1:0] p0_resp_rdata, p1_resp_rdata;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata;
  logic [SW-1:0] bram_we_perbyte;

  logic          f_p0_req_ready, f_p1_req_ready, f_p0_resp_valid, f_p1_resp_valid;
  logic [DW-1:0] f_p0_resp_rdata, f_p1_resp_rdata;
  logic          f_bram_en;
  logic [AW-1:0] f_bram_addr;
  logic [DW-1:0] f_bram_wdata, f_bram_rdata;
  logic [SW-1:0] f_bram_we_perbyte;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_we_perbyte(bram_we_perbyte), .bram_rdata(bram_rdata)
  );

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fix (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(f_p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb), .p0_resp_valid(f_p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(f_p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(f_p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb), .p1_resp_valid(f_p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(f_p1_resp_rdata),
    .bram_en(f_bram_en), .bram_addr(f_bram_addr), .bram_wdata(f_bram_wdata),
    .bram_we_perbyte(f_bram_we_perbyte), .bram_rdata(f_bram_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Storage: registered read, byte-merged write, returns zero on a write access.
  always @(posedge clock) begin
    if (bram_en) begin
      if (bram_we_perbyte != '0) begin
        for (int i = 0; i < SW; i++)
          if (bram_we_perbyte[i]) mem[bram_addr][8*i +: 8] = bram_wdata[8*i +: 8];
        bram_rdata <= '0;
      end else begin
        bram_rdata <= mem[bram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    if (p == 0) begin
      p0_req_valid = v; p0_req_addr = a; p0_req_wdata = wd; p0_req_wstrb = ws;
    end else begin
      p1_req_valid = v; p1_req_addr = a; p1_req_wdata = wd; p1_req_wstrb = ws;
    end
  endtask

  task automatic single(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [DW-1:0] exp);
    drive(p, 1'b1, a, wd, ws);
    if (p == 0) q0.push_back(exp); else q1.push_back(exp);
    @(negedge clock);
    check("single_gnt",   (p == 0) ? p0_req_ready : p1_req_ready, 1);
    check("single_other", (p == 0) ? p1_req_ready : p0_req_ready, 0);
    check("single_en",    bram_en, 1);
    check("single_addr",  bram_addr, a);
    check("single_wdata", bram_wdata, wd);
    check("single_we",    bram_we_perbyte, ws);
    step();
    drive(p, 1'b0, '0, '0, '0);
    @(negedge clock);
    check("single_en_t1", bram_en, 0);
    check("single_rv_t1", (p == 0) ? p0_resp_valid : p1_resp_valid, 0);
    step();
    @(negedge clock);
    check("single_rv_t2", (p == 0) ? p0_resp_valid : p1_resp_valid, 1);
    step();
  endtask

  // Response monitor: latency, hold stability and scoreboard pop on each accepted response.
  logic          pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
  logic [DW-1:0] pd0 = '0, pd1 = '0;
  int            g0 = 0, g1 = 0;

  always @(negedge clock) begin
    if (reset) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (p0_resp_valid && !pv0) check("p0_latency", 64'(cyc - g0), 64'd2);
      if (pv0 && !pr0 && p0_resp_valid) check("p0_hold", p0_resp_rdata, pd0);
      if (p0_resp_valid && p0_resp_ready) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p0_unexpected_resp: got %h expected none (cycle %0d)", p0_resp_rdata, cyc);
        end else check("p0_rdata", p0_resp_rdata, q0.pop_front());
      end
      if (p0_req_ready) g0 = cyc;
      pv0 = p0_resp_valid; pr0 = p0_resp_ready; pd0 = p0_resp_rdata;

      if (p1_resp_valid && !pv1) check("p1_latency", 64'(cyc - g1), 64'd2);
      if (pv1 && !pr1 && p1_resp_valid) check("p1_hold", p1_resp_rdata, pd1);
      if (p1_resp_valid && p1_resp_ready) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p1_unexpected_resp: got %h expected none (cycle %0d)", p1_resp_rdata, cyc);
        end else check("p1_rdata", p1_resp_rdata, q1.pop_front());
      end
      if (p1_req_ready) g1 = cyc;
      pv1 = p1_resp_valid; pr1 = p1_resp_ready; pd1 = p1_resp_rdata;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] g0v, g1v, rvv;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    p0_resp_ready = 1'b1;
    p1_resp_ready = 1'b1;
    f_bram_rdata  = '0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h0010] = D10;
    mem[13'h0020] = D20;
    mem[13'h0021] = D21;

    // Requests under reset are never granted.
    repeat (2) step();
    drive(0, 1'b1, 13'h0010, '0, '0);
    drive(1, 1'b1, 13'h0021, '0, '0);
    @(negedge clock);
    check("rst_p0_ready", p0_req_ready, 0);
    check("rst_p1_ready", p1_req_ready, 0);
    check("rst_bram_en",  bram_en, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_p0_rv",    p0_resp_valid, 0);
    check("rst_p1_rv",    p1_resp_valid, 0);
    check("rst_p0_rdata", p0_resp_rdata, 0);
    check("rst_p1_rdata", p1_resp_rdata, 0);
    step();
    reset = 1'b0;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);

    single(0, 13'h0010, '0, 8'h00, D10);
    single(1, 13'h1FFF, '1, 8'h81, 64'h0);
    single(1, 13'h1FFF, '0, 8'h00, 64'hFF00_0000_0000_00FF);

    // Continuous contention alternates; last grant was p1 so p0 starts.
    drive(0, 1'b1, 13'h0020, '0, '0);
    drive(1, 1'b1, 13'h0021, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("cont_p0_gnt", p0_req_ready, (i % 2 == 0));
      check("cont_p1_gnt", p1_req_ready, (i % 2 == 1));
      check("cont_en",     bram_en, 1);
      check("cont_addr",   bram_addr, (i % 2 == 0) ? 13'h0020 : 13'h0021);
      check("cont_fix_p0", f_p0_req_ready, (i % 2 == 0));
      check("cont_fix_p1", f_p1_req_ready, (i % 2 == 1));
      if (i % 2 == 0) q0.push_back(D20); else q1.push_back(D21);
      step();
    end
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Tie after a p0 grant: round-robin picks p1, fixed priority picks p0.
    single(0, 13'h0010, '0, 8'h00, D10);
    drive(0, 1'b1, 13'h0020, '0, '0);
    drive(1, 1'b1, 13'h0021, '0, '0);
    @(negedge clock);
    check("tie_p1_gnt",   p1_req_ready, 1);
    check("tie_p0_gnt",   p0_req_ready, 0);
    check("tie_addr",     bram_addr, 13'h0021);
    check("tie_fix_p0",   f_p0_req_ready, 1);
    check("tie_fix_p1",   f_p1_req_ready, 0);
    check("tie_fix_addr", f_bram_addr, 13'h0020);
    q1.push_back(D21);
    step();
    @(negedge clock);
    check("tie2_p0_gnt", p0_req_ready, 1);
    check("tie2_p1_gnt", p1_req_ready, 0);
    check("tie2_fix_p1", f_p1_req_ready, 1);
    q0.push_back(D20);
    step();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Back-pressure on p0 for 5 cycles while p1 keeps being served.
    g0v = 8'h81;
    g1v = 8'h2A;
    rvv = 8'hFC;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, (i == 0) ? 13'h0010 : 13'h0020, '0, '0);
      drive(1, (i >= 1), 13'h0021, '0, '0);
      p0_resp_ready = (i == 7);
      if (i == 0) q0.push_back(D10);
      @(negedge clock);
      check("bp_p0_gnt", p0_req_ready, g0v[i]);
      check("bp_p1_gnt", p1_req_ready, g1v[i]);
      check("bp_p0_rv",  p0_resp_valid, rvv[i]);
      check("bp_en",     bram_en, g0v[i] | g1v[i]);
      if (g1v[i]) q1.push_back(D21);
      if (i == 7) q0.push_back(D20);
      step();
    end
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    p0_resp_ready = 1'b1;
    repeat (3) step();

    // Reset one cycle after a p0 grant drops the response and restores p0's tie priority.
    drive(0, 1'b1, 13'h0010, '0, '0);
    @(negedge clock);
    check("rm_gnt", p0_req_ready, 1);
    step();
    reset = 1'b1;
    drive(0, 1'b1, 13'h0020, '0, '0);
    drive(1, 1'b1, 13'h0021, '0, '0);
    @(negedge clock);
    check("rm_p0_ready", p0_req_ready, 0);
    check("rm_p1_ready", p1_req_ready, 0);
    check("rm_en",       bram_en, 0);
    check("rm_addr",     bram_addr, 0);
    check("rm_wdata",    bram_wdata, 0);
    check("rm_we",       bram_we_perbyte, 0);
    check("rm_p0_rv",    p0_resp_valid, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rm_post_rv",  p0_resp_valid, 0);
    check("rm_tie_p0",   p0_req_ready, 1);
    check("rm_tie_p1",   p1_req_ready, 0);
    q0.push_back(D20);
    step();
    @(negedge clock);
    check("rm_next_p1",  p1_req_ready, 1);
    q1.push_back(D21);
    step();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (3) step();

    // Idle with busy-looking request fields: the storage port stays quiet.
    drive(0, 1'b0, 13'h1234, 64'hDEAD_BEEF_0000_1111, 8'hFF);
    drive(1, 1'b0, 13'h0ABC, 64'h5555_AAAA_5555_AAAA, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_en",       bram_en, 0);
      check("idle_addr",     bram_addr, 0);
      check("idle_wdata",    bram_wdata, 0);
      check("idle_we",       bram_we_perbyte, 0);
      check("idle_fix_en",   f_bram_en, 0);
      check("idle_fix_wd",   f_bram_wdata, 0);
      check("idle_fix_we",   f_bram_we_perbyte, 0);
      check("idle_fix_rv0",  f_p0_resp_valid, 0);
      check("idle_fix_rv1",  f_p1_resp_valid, 0);
      step();
    end

    check("q0_drained",    64'(q0.size()), 0);
    check("q1_drained",    64'(q1.size()), 0);
    check("fix_p0_rdata",  f_p0_resp_rdata, 0);
    check("fix_p1_rdata",  f_p1_resp_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
